// File: rtl/xdma_byp_pkg.sv
// ----------------------------------------------------------------------------
// xdma_byp_pkg
// Shared definitions for the XDMA descriptor-bypass scheduler:
//   - descriptor field widths (source/destination address, byte length, control)
//   - tag_w(): width of a requester tag for a given requester count
//   - byp_state_e: scheduler FSM states
// ----------------------------------------------------------------------------
package xdma_byp_pkg;

    localparam int ADDR_W = 64;
    localparam int LEN_W  = 28;
    localparam int CTL_W  = 16;

    // Bits needed to name one of n requesters (never less than 1).
    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        ARB   = 1'b0,
        ISSUE = 1'b1
    } byp_state_e;

endpackage

// File: rtl/xdma_byp_tag_fifo.sv
// ----------------------------------------------------------------------------
// xdma_byp_tag_fifo
// Synchronous FIFO of requester tags, one entry per descriptor in flight.
// Push and pop may occur in the same cycle; the occupancy count is exported.
// Ports:
//   CLK, RST      clock, synchronous active-high reset (empties the FIFO)
//   push_i        write push_tag_i (ignored when full)
//   push_tag_i    tag to write
//   pop_i         drop the head entry (ignored when empty)
//   head_tag_o    oldest tag
//   count_o       number of stored tags
//   empty_o       count_o == 0
//   full_o        count_o == DEPTH
// ----------------------------------------------------------------------------
module xdma_byp_tag_fifo #(
    parameter int TAG_W = 2,
    parameter int DEPTH = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       push_i,
    input  logic [TAG_W-1:0]           push_tag_i,
    input  logic                       pop_i,
    output logic [TAG_W-1:0]           head_tag_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == CNT_W'(DEPTH));
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign head_tag_o = mem_q[rd_q];
    assign count_o    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_W'(1);
            if (do_pop)  rd_q <= rd_q + PTR_W'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_q] <= push_tag_i;
    end

endmodule

// File: rtl/xdma_dsc_byp_sched.sv
// ----------------------------------------------------------------------------
// xdma_dsc_byp_sched
// Shares one XDMA descriptor-bypass channel among NUM_REQ requesters using
// round-robin arbitration, one descriptor at a time, at most MAX_OUTSTANDING
// in flight. In-order completions are routed back to the requester that
// issued the descriptor as a one-cycle done_pulse.
// Ports:
//   CLK, RST            user_clk, synchronous active-high reset
//   req_valid/ready     per-requester handshake (ready is a one-cycle accept)
//   req_src_addr/dst_addr/len/ctl  packed per-requester descriptor fields
//   done_pulse          per-requester completion pulse (registered)
//   dsc_byp_*           XDMA descriptor-bypass interface
//   dsc_byp_desc_done   XDMA completion pulse, one per descriptor, in order
//   outstanding_cnt     descriptors loaded but not yet completed
//   err_spurious_done   sticky: completion seen with nothing outstanding
// ----------------------------------------------------------------------------
module xdma_dsc_byp_sched
    import xdma_byp_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]            req_src_addr,
    input  logic [NUM_REQ*ADDR_W-1:0]            req_dst_addr,
    input  logic [NUM_REQ*LEN_W-1:0]             req_len,
    input  logic [NUM_REQ*CTL_W-1:0]             req_ctl,
    output logic [NUM_REQ-1:0]                   done_pulse,
    input  logic                                 dsc_byp_ready,
    output logic                                 dsc_byp_load,
    output logic [ADDR_W-1:0]                    dsc_byp_src_addr,
    output logic [ADDR_W-1:0]                    dsc_byp_dst_addr,
    output logic [LEN_W-1:0]                     dsc_byp_len,
    output logic [CTL_W-1:0]                     dsc_byp_ctl,
    input  logic                                 dsc_byp_desc_done,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_cnt,
    output logic                                 err_spurious_done
);

    localparam int TAG_W = tag_w(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    byp_state_e          state_q;
    logic [TAG_W-1:0]    rr_q;
    logic [TAG_W-1:0]    tag_q;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [LEN_W-1:0]    len_q;
    logic [CTL_W-1:0]    ctl_q;
    logic [NUM_REQ-1:0]  done_q;
    logic                err_q;

    logic [ADDR_W-1:0]   src_a [NUM_REQ];
    logic [ADDR_W-1:0]   dst_a [NUM_REQ];
    logic [LEN_W-1:0]    len_a [NUM_REQ];
    logic [CTL_W-1:0]    ctl_a [NUM_REQ];

    logic                gnt_found;
    logic [TAG_W-1:0]    gnt_idx;
    logic [TAG_W-1:0]    rr_d;
    logic                grant;
    int                  cand;
    logic [TAG_W-1:0]    cand_t;

    logic [TAG_W-1:0]    head_tag;
    logic [CNT_W-1:0]    fifo_cnt;
    logic                fifo_empty;
    logic                fifo_full;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign src_a[i] = req_src_addr[ADDR_W*i +: ADDR_W];
        assign dst_a[i] = req_dst_addr[ADDR_W*i +: ADDR_W];
        assign len_a[i] = req_len[LEN_W*i +: LEN_W];
        assign ctl_a[i] = req_ctl[CTL_W*i +: CTL_W];
    end

    // Round-robin pick: scan downwards from the farthest candidate so the
    // last hit (closest to rr_q, wrapping) wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_t    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_t = TAG_W'(cand);
            if (req_valid[cand_t]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_t;
            end
        end
    end

    assign rr_d = (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);

    // Full uses the pre-cycle count, so a completion in the same cycle does
    // not open a slot until the next cycle. RST gates both strobes so nothing
    // is accepted or loaded while the block is being cleared.
    assign grant        = !RST && (state_q == ARB) && gnt_found && !fifo_full;
    assign req_ready    = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign dsc_byp_load = !RST && (state_q == ISSUE) && dsc_byp_ready;

    assign dsc_byp_src_addr  = src_q;
    assign dsc_byp_dst_addr  = dst_q;
    assign dsc_byp_len       = len_q;
    assign dsc_byp_ctl       = ctl_q;
    assign done_pulse        = done_q;
    assign err_spurious_done = err_q;
    assign outstanding_cnt   = fifo_cnt;

    xdma_byp_tag_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .push_i     (dsc_byp_load),
        .push_tag_i (tag_q),
        .pop_i      (dsc_byp_desc_done),
        .head_tag_o (head_tag),
        .count_o    (fifo_cnt),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ARB;
            rr_q    <= '0;
            tag_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            ctl_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ARB: begin
                    if (grant) begin
                        src_q   <= src_a[gnt_idx];
                        dst_q   <= dst_a[gnt_idx];
                        len_q   <= len_a[gnt_idx];
                        ctl_q   <= ctl_a[gnt_idx];
                        tag_q   <= gnt_idx;
                        rr_q    <= rr_d;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (dsc_byp_load) state_q <= ARB;
                end
                default: state_q <= ARB;
            endcase

            // Completion demux: the head tag names the oldest descriptor.
            done_q <= '0;
            if (dsc_byp_desc_done) begin
                if (fifo_empty) err_q  <= 1'b1;
                else            done_q <= NUM_REQ'(1) << head_tag;
            end
        end
    end

endmodule

// File: tb/tb_xdma_dsc_byp_sched.sv
module tb_xdma_dsc_byp_sched;

    localparam int NR = 4;
    localparam int MO = 8;
    localparam int CW = $clog2(MO + 1);

    logic              CLK = 1'b0;
    logic              RST;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*64-1:0]  req_src_addr;
    logic [NR*64-1:0]  req_dst_addr;
    logic [NR*28-1:0]  req_len;
    logic [NR*16-1:0]  req_ctl;
    logic [NR-1:0]     done_pulse;
    logic              dsc_byp_ready;
    logic              dsc_byp_load;
    logic [63:0]       dsc_byp_src_addr;
    logic [63:0]       dsc_byp_dst_addr;
    logic [27:0]       dsc_byp_len;
    logic [15:0]       dsc_byp_ctl;
    logic              dsc_byp_desc_done;
    logic [CW-1:0]     outstanding_cnt;
    logic              err_spurious_done;

    int n_checks = 0;
    int n_fail   = 0;

    xdma_dsc_byp_sched #(.NUM_REQ(NR), .MAX_OUTSTANDING(MO)) dut (
        .CLK               (CLK),
        .RST               (RST),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_src_addr      (req_src_addr),
        .req_dst_addr      (req_dst_addr),
        .req_len           (req_len),
        .req_ctl           (req_ctl),
        .done_pulse        (done_pulse),
        .dsc_byp_ready     (dsc_byp_ready),
        .dsc_byp_load      (dsc_byp_load),
        .dsc_byp_src_addr  (dsc_byp_src_addr),
        .dsc_byp_dst_addr  (dsc_byp_dst_addr),
        .dsc_byp_len       (dsc_byp_len),
        .dsc_byp_ctl       (dsc_byp_ctl),
        .dsc_byp_desc_done (dsc_byp_desc_done),
        .outstanding_cnt   (outstanding_cnt),
        .err_spurious_done (err_spurious_done)
    );

    always #5 CLK = ~CLK;

    // Inputs change 2 ns after the rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    function automatic logic [63:0] fsrc(input int i);
        return 64'hA000_0000_0000_0000 + 64'(i) * 64'h0000_0001_0000_0011;
    endfunction
    function automatic logic [63:0] fdst(input int i);
        return 64'hB000_0000_0000_0000 + 64'(i) * 64'h0000_0100_0000_0203;
    endfunction
    function automatic logic [27:0] flen(input int i);
        return 28'h0100 + 28'(i) * 28'h0040;
    endfunction
    function automatic logic [15:0] fctl(input int i);
        return 16'h8000 | 16'(i);
    endfunction

    task automatic set_req(input int i, input logic [63:0] s, input logic [63:0] d,
                           input logic [27:0] l, input logic [15:0] c);
        req_src_addr[64*i +: 64] = s;
        req_dst_addr[64*i +: 64] = d;
        req_len[28*i +: 28]      = l;
        req_ctl[16*i +: 16]      = c;
    endtask

    task automatic set_fixed_fields();
        for (int i = 0; i < NR; i++) set_req(i, fsrc(i), fdst(i), flen(i), fctl(i));
    endtask

    task automatic do_reset();
        RST = 1'b1;
        req_valid = '0;
        dsc_byp_ready = 1'b0;
        dsc_byp_desc_done = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        set_fixed_fields();
        RST = 1'b1;
        req_valid = '1;
        dsc_byp_ready = 1'b1;
        dsc_byp_desc_done = 1'b0;
        tick();
        tick();
        #1;
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
        n_checks++; if (dsc_byp_load !== 1'b0) begin n_fail++; $display("FAIL rst_load got=%b exp=0", dsc_byp_load); end
        n_checks++; if (dsc_byp_src_addr !== 64'h0) begin n_fail++; $display("FAIL rst_src got=%h exp=0", dsc_byp_src_addr); end
        n_checks++; if (dsc_byp_len !== 28'h0) begin n_fail++; $display("FAIL rst_len got=%h exp=0", dsc_byp_len); end
        n_checks++; if (done_pulse !== '0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", done_pulse); end
        n_checks++; if (outstanding_cnt !== '0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", outstanding_cnt); end
        n_checks++; if (err_spurious_done !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err_spurious_done); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        set_fixed_fields();
        req_valid = 4'b0100;
        dsc_byp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL t1_ready got=%b exp=0100", req_ready); end
        n_checks++; if (dsc_byp_load !== 1'b0) begin n_fail++; $display("FAIL t1_load0 got=%b exp=0", dsc_byp_load); end
        tick();
        req_valid = '0;
        #1;
        n_checks++; if (dsc_byp_load !== 1'b1) begin n_fail++; $display("FAIL t1_load1 got=%b exp=1", dsc_byp_load); end
        n_checks++; if (dsc_byp_src_addr !== fsrc(2)) begin n_fail++; $display("FAIL t1_src got=%h exp=%h", dsc_byp_src_addr, fsrc(2)); end
        n_checks++; if (dsc_byp_dst_addr !== fdst(2)) begin n_fail++; $display("FAIL t1_dst got=%h exp=%h", dsc_byp_dst_addr, fdst(2)); end
        n_checks++; if (dsc_byp_len !== flen(2)) begin n_fail++; $display("FAIL t1_len got=%h exp=%h", dsc_byp_len, flen(2)); end
        n_checks++; if (dsc_byp_ctl !== fctl(2)) begin n_fail++; $display("FAIL t1_ctl got=%h exp=%h", dsc_byp_ctl, fctl(2)); end
        n_checks++; if (outstanding_cnt !== CW'(0)) begin n_fail++; $display("FAIL t1_cnt0 got=%0d exp=0", outstanding_cnt); end
        tick();
        #1;
        n_checks++; if (outstanding_cnt !== CW'(1)) begin n_fail++; $display("FAIL t1_cnt1 got=%0d exp=1", outstanding_cnt); end
        n_checks++; if (dsc_byp_load !== 1'b0) begin n_fail++; $display("FAIL t1_load2 got=%b exp=0", dsc_byp_load); end
        tick(); tick(); tick(); tick();
        dsc_byp_desc_done = 1'b1;
        #1;
        n_checks++; if (done_pulse !== '0) begin n_fail++; $display("FAIL t1_done_early got=%b exp=0", done_pulse); end
        tick();
        dsc_byp_desc_done = 1'b0;
        #1;
        n_checks++; if (done_pulse !== 4'b0100) begin n_fail++; $display("FAIL t1_done got=%b exp=0100", done_pulse); end
        n_checks++; if (outstanding_cnt !== CW'(0)) begin n_fail++; $display("FAIL t1_cnt_end got=%0d exp=0", outstanding_cnt); end
        tick();
        #1;
        n_checks++; if (done_pulse !== '0) begin n_fail++; $display("FAIL t1_done_once got=%b exp=0", done_pulse); end
        n_checks++; if (err_spurious_done !== 1'b0) begin n_fail++; $display("FAIL t1_err got=%b exp=0", err_spurious_done); end
    endtask

    task automatic test_rr_full();
        int grants[$];
        int last_g;
        int loads;
        do_reset();
        set_fixed_fields();
        req_valid = '1;
        dsc_byp_ready = 1'b1;
        last_g = -1;
        loads = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (req_ready !== '0) begin
                n_checks++; if ($countones(req_ready) != 1) begin n_fail++; $display("FAIL t2_onehot got=%b", req_ready); end
                for (int i = 0; i < NR; i++) if (req_ready[i]) begin grants.push_back(i); last_g = i; end
            end else if (loads == MO) begin
                n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL t2_blocked got=%b exp=0", req_ready); end
            end
            if (dsc_byp_load === 1'b1) begin
                loads++;
                n_checks++; if (dsc_byp_src_addr !== fsrc(last_g)) begin n_fail++; $display("FAIL t2_src got=%h exp=%h", dsc_byp_src_addr, fsrc(last_g)); end
            end
            tick();
        end
        #1;
        n_checks++; if (grants.size() != MO) begin n_fail++; $display("FAIL t2_ngrants got=%0d exp=%0d", grants.size(), MO); end
        for (int k = 0; k < grants.size() && k < MO; k++) begin
            n_checks++; if (grants[k] != k % NR) begin n_fail++; $display("FAIL t2_order idx=%0d got=%0d exp=%0d", k, grants[k], k % NR); end
        end
        n_checks++; if (loads != MO) begin n_fail++; $display("FAIL t2_loads got=%0d exp=%0d", loads, MO); end
        n_checks++; if (outstanding_cnt !== CW'(MO)) begin n_fail++; $display("FAIL t2_cnt got=%0d exp=%0d", outstanding_cnt, MO); end
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL t2_ready_end got=%b exp=0", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_stall();
        do_reset();
        set_fixed_fields();
        req_valid = 4'b0010;
        dsc_byp_ready = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL t3_ready got=%b exp=0010", req_ready); end
        tick();
        req_valid = '0;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_checks++; if (dsc_byp_load !== 1'b0) begin n_fail++; $display("FAIL t3_load_stall cyc=%0d got=%b exp=0", c, dsc_byp_load); end
            n_checks++; if (dsc_byp_src_addr !== fsrc(1) || dsc_byp_len !== flen(1) || dsc_byp_ctl !== fctl(1))
                begin n_fail++; $display("FAIL t3_fields cyc=%0d got=%h/%h/%h exp=%h/%h/%h", c, dsc_byp_src_addr, dsc_byp_len, dsc_byp_ctl, fsrc(1), flen(1), fctl(1)); end
            tick();
        end
        dsc_byp_ready = 1'b1;
        #1;
        n_checks++; if (dsc_byp_load !== 1'b1) begin n_fail++; $display("FAIL t3_load got=%b exp=1", dsc_byp_load); end
        n_checks++; if (dsc_byp_dst_addr !== fdst(1)) begin n_fail++; $display("FAIL t3_dst got=%h exp=%h", dsc_byp_dst_addr, fdst(1)); end
        tick();
        #1;
        n_checks++; if (outstanding_cnt !== CW'(1)) begin n_fail++; $display("FAIL t3_cnt got=%0d exp=1", outstanding_cnt); end
    endtask

    task automatic test_full_swap();
        int c;
        do_reset();
        set_fixed_fields();
        req_valid = '1;
        dsc_byp_ready = 1'b1;
        c = 0;
        while (outstanding_cnt !== CW'(MO) && c < 40) begin tick(); c++; end
        #1;
        n_checks++; if (outstanding_cnt !== CW'(MO)) begin n_fail++; $display("FAIL t4_fill got=%0d exp=%0d", outstanding_cnt, MO); end
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL t4_full_ready got=%b exp=0", req_ready); end
            tick();
        end
        dsc_byp_desc_done = 1'b1;
        #1;
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL t4_precount got=%b exp=0", req_ready); end
        tick();
        dsc_byp_desc_done = 1'b0;
        #1;
        n_checks++; if (done_pulse !== 4'b0001) begin n_fail++; $display("FAIL t4_done0 got=%b exp=0001", done_pulse); end
        n_checks++; if (outstanding_cnt !== CW'(MO - 1)) begin n_fail++; $display("FAIL t4_cnt7 got=%0d exp=%0d", outstanding_cnt, MO - 1); end
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL t4_regrant got=%b exp=0001", req_ready); end
        tick();
        dsc_byp_desc_done = 1'b1;
        #1;
        n_checks++; if (dsc_byp_load !== 1'b1) begin n_fail++; $display("FAIL t4_swap_load got=%b exp=1", dsc_byp_load); end
        tick();
        dsc_byp_desc_done = 1'b0;
        #1;
        n_checks++; if (outstanding_cnt !== CW'(MO - 1)) begin n_fail++; $display("FAIL t4_swap_cnt got=%0d exp=%0d", outstanding_cnt, MO - 1); end
        n_checks++; if (done_pulse !== 4'b0010) begin n_fail++; $display("FAIL t4_done1 got=%b exp=0010", done_pulse); end
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL t4_grant1 got=%b exp=0010", req_ready); end
        tick();
        #1;
        n_checks++; if (dsc_byp_load !== 1'b1) begin n_fail++; $display("FAIL t4_load8 got=%b exp=1", dsc_byp_load); end
        tick();
        #1;
        n_checks++; if (outstanding_cnt !== CW'(MO)) begin n_fail++; $display("FAIL t4_cnt8 got=%0d exp=%0d", outstanding_cnt, MO); end
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL t4_reblock got=%b exp=0", req_ready); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_spurious();
        do_reset();
        dsc_byp_desc_done = 1'b1;
        tick();
        dsc_byp_desc_done = 1'b0;
        #1;
        n_checks++; if (done_pulse !== '0) begin n_fail++; $display("FAIL t5_done got=%b exp=0", done_pulse); end
        n_checks++; if (err_spurious_done !== 1'b1) begin n_fail++; $display("FAIL t5_err got=%b exp=1", err_spurious_done); end
        n_checks++; if (outstanding_cnt !== '0) begin n_fail++; $display("FAIL t5_cnt got=%0d exp=0", outstanding_cnt); end
        tick(); tick(); tick();
        #1;
        n_checks++; if (err_spurious_done !== 1'b1) begin n_fail++; $display("FAIL t5_sticky got=%b exp=1", err_spurious_done); end
        do_reset();
        #1;
        n_checks++; if (err_spurious_done !== 1'b0) begin n_fail++; $display("FAIL t5_clear got=%b exp=0", err_spurious_done); end
    endtask

    task automatic test_reset_mid();
        int c;
        do_reset();
        set_fixed_fields();
        req_valid = '1;
        dsc_byp_ready = 1'b1;
        c = 0;
        while (outstanding_cnt !== CW'(3) && c < 40) begin tick(); c++; end
        dsc_byp_ready = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL t6_grant3 got=%b exp=1000", req_ready); end
        tick();
        req_valid = '0;
        #1;
        n_checks++; if (outstanding_cnt !== CW'(3)) begin n_fail++; $display("FAIL t6_cnt3 got=%0d exp=3", outstanding_cnt); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        dsc_byp_ready = 1'b1;
        #1;
        n_checks++; if (dsc_byp_load !== 1'b0) begin n_fail++; $display("FAIL t6_load got=%b exp=0", dsc_byp_load); end
        n_checks++; if (outstanding_cnt !== '0) begin n_fail++; $display("FAIL t6_cnt got=%0d exp=0", outstanding_cnt); end
        n_checks++; if (dsc_byp_src_addr !== '0 || dsc_byp_dst_addr !== '0 || dsc_byp_len !== '0 || dsc_byp_ctl !== '0)
            begin n_fail++; $display("FAIL t6_fields got=%h/%h/%h/%h exp=0", dsc_byp_src_addr, dsc_byp_dst_addr, dsc_byp_len, dsc_byp_ctl); end
        n_checks++; if (done_pulse !== '0 || req_ready !== '0 || err_spurious_done !== 1'b0)
            begin n_fail++; $display("FAIL t6_ctrl got=%b/%b/%b exp=0", done_pulse, req_ready, err_spurious_done); end
        tick();
        #1;
        n_checks++; if (dsc_byp_load !== 1'b0) begin n_fail++; $display("FAIL t6_dropped got=%b exp=0", dsc_byp_load); end
        dsc_byp_desc_done = 1'b1;
        tick();
        dsc_byp_desc_done = 1'b0;
        #1;
        n_checks++; if (err_spurious_done !== 1'b1) begin n_fail++; $display("FAIL t6_err got=%b exp=1", err_spurious_done); end
        n_checks++; if (done_pulse !== '0) begin n_fail++; $display("FAIL t6_done got=%b exp=0", done_pulse); end
    endtask

    // Reference model: a pending descriptor (accepted, not yet loaded), a
    // queue of in-flight requester ids and the round-robin start position.
    task automatic test_random();
        int            tagq[$];
        bit            pend;
        int            pend_tag;
        logic [63:0]   pend_src, pend_dst;
        logic [27:0]   pend_len;
        logic [15:0]   pend_ctl;
        int            rr;
        int            g;
        logic [NR-1:0] exp_ready, exp_done;
        bit            exp_load, exp_err;
        do_reset();
        pend = 0; pend_tag = 0; rr = 0; exp_done = '0; exp_err = 0;
        pend_src = '0; pend_dst = '0; pend_len = '0; pend_ctl = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(2) == 0) begin
                    req_valid[i] = 1'b1;
                    set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 28'($urandom), 16'($urandom));
                end
            end
            dsc_byp_ready = ($urandom_range(9) < 7);
            if (tagq.size() > 0) dsc_byp_desc_done = ($urandom_range(9) < 3);
            else                 dsc_byp_desc_done = ($urandom_range(199) == 0);
            #1;
            g = -1;
            if (!pend && tagq.size() < MO) begin
                for (int k = 0; k < NR; k++) begin
                    if (g < 0 && req_valid[(rr + k) % NR]) g = (rr + k) % NR;
                end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            exp_load = pend && dsc_byp_ready;
            n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_ready); end
            n_checks++; if (dsc_byp_load !== exp_load) begin n_fail++; $display("FAIL rnd_load cyc=%0d got=%b exp=%b", c, dsc_byp_load, exp_load); end
            if (exp_load) begin
                n_checks++; if (dsc_byp_src_addr !== pend_src || dsc_byp_dst_addr !== pend_dst || dsc_byp_len !== pend_len || dsc_byp_ctl !== pend_ctl)
                    begin n_fail++; $display("FAIL rnd_fields cyc=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", c, dsc_byp_src_addr, dsc_byp_dst_addr, dsc_byp_len, dsc_byp_ctl, pend_src, pend_dst, pend_len, pend_ctl); end
            end
            n_checks++; if (outstanding_cnt !== CW'(tagq.size())) begin n_fail++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, outstanding_cnt, tagq.size()); end
            n_checks++; if (done_pulse !== exp_done) begin n_fail++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", c, done_pulse, exp_done); end
            n_checks++; if (err_spurious_done !== exp_err) begin n_fail++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, err_spurious_done, exp_err); end
            exp_done = '0;
            if (dsc_byp_desc_done) begin
                if (tagq.size() > 0) begin exp_done[tagq[0]] = 1'b1; void'(tagq.pop_front()); end
                else exp_err = 1;
            end
            if (exp_load) begin tagq.push_back(pend_tag); pend = 0; end
            if (g >= 0) begin
                pend = 1; pend_tag = g;
                pend_src = req_src_addr[64*g +: 64];
                pend_dst = req_dst_addr[64*g +: 64];
                pend_len = req_len[28*g +: 28];
                pend_ctl = req_ctl[16*g +: 16];
                rr = (g + 1) % NR;
            end
            tick();
            if (g >= 0) req_valid[g] = 1'b0;
        end
        req_valid = '0;
        dsc_byp_desc_done = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        req_valid = '0;
        req_src_addr = '0;
        req_dst_addr = '0;
        req_len = '0;
        req_ctl = '0;
        dsc_byp_ready = 1'b0;
        dsc_byp_desc_done = 1'b0;
        test_reset();
        test_single();
        test_rr_full();
        test_stall();
        test_full_swap();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
